// File: rtl/mc_dp_pkg.sv
// Shared encodings for the multi-cycle datapath: ALU opcodes, branch types, FSM states.
package mc_dp_pkg;

  localparam logic [5:0] ALU_ADD  = 6'd0;
  localparam logic [5:0] ALU_SUB  = 6'd1;
  localparam logic [5:0] ALU_AND  = 6'd2;
  localparam logic [5:0] ALU_OR   = 6'd3;
  localparam logic [5:0] ALU_XOR  = 6'd4;
  localparam logic [5:0] ALU_SLL  = 6'd5;
  localparam logic [5:0] ALU_SRL  = 6'd6;
  localparam logic [5:0] ALU_SRA  = 6'd7;
  localparam logic [5:0] ALU_SLT  = 6'd8;
  localparam logic [5:0] ALU_SLTU = 6'd9;
  localparam logic [5:0] ALU_EQ   = 6'd10;
  localparam logic [5:0] ALU_NE   = 6'd11;
  localparam logic [5:0] ALU_GE   = 6'd12;
  localparam logic [5:0] ALU_LT   = 6'd13;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BGE  = 3'd3;
  localparam logic [2:0] BR_BLT  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MEM_REQ,
    ST_MEM_WAIT,
    ST_WB
  } dp_state_t;

  // Codes above BR_BLT are treated as "no branch".
  function automatic logic is_branch(input logic [2:0] br);
    return (br != BR_NONE) && (br <= BR_BLT);
  endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU; compares return 0/1 and unknown opcodes return 0.
module mc_alu
  import mc_dp_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [5:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLL:  y = a << shamt;
      ALU_SRL:  y = a >> shamt;
      ALU_SRA:  y = XLEN'($signed(a) >>> shamt);
      ALU_SLT:  y = XLEN'($signed(a) < $signed(b));
      ALU_SLTU: y = XLEN'(a < b);
      ALU_EQ:   y = XLEN'(a == b);
      ALU_NE:   y = XLEN'(a != b);
      ALU_GE:   y = XLEN'($signed(a) >= $signed(b));
      ALU_LT:   y = XLEN'($signed(a) < $signed(b));
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/mc_data_path.sv
// Multi-cycle datapath: one command at a time through EXEC, optional memory access, then WB.
module mc_data_path
  import mc_dp_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int RA    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [RA-1:0]   rs1,
  input  logic [RA-1:0]   rs2,
  input  logic [RA-1:0]   rd,
  input  logic [5:0]      alu_control,
  input  logic            alu_src,
  input  logic            reg_write,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            mem_to_reg,
  input  logic            lui_control,
  input  logic [2:0]      br_type,
  input  logic [XLEN-1:0] imm_val,
  input  logic [XLEN-1:0] imm_val_lui,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_we,
  output logic [XLEN-1:0] mem_req_addr,
  output logic [XLEN-1:0] mem_req_wdata,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_rdata,
  output logic            done_valid,
  output logic            branch_taken,
  output logic [XLEN-1:0] wb_data
);

  dp_state_t       state_reg;
  logic [RA-1:0]   rs1_reg, rs2_reg, rd_reg;
  logic [5:0]      alu_ctl_reg;
  logic            alu_src_reg, reg_write_reg, mem_read_reg, mem_write_reg, m2r_reg, lui_reg;
  logic [2:0]      br_reg;
  logic [XLEN-1:0] imm_reg, imm_lui_reg;
  logic [XLEN-1:0] alu_res_reg, store_data_reg, load_data_reg, wb_data_reg;
  logic            mem_req_valid_reg, done_reg, branch_reg;

  logic [XLEN-1:0] rf [NREGS];
  logic [XLEN-1:0] rs1_val, rs2_val, op2, alu_y;
  logic [NREGS-1:0] we_vec;

  function automatic logic [XLEN-1:0] select_wb(input logic lui, input logic m2r,
                                               input logic [XLEN-1:0] imm_lui,
                                               input logic [XLEN-1:0] ld,
                                               input logic [XLEN-1:0] alu);
    if (lui) return imm_lui;
    if (m2r) return ld;
    return alu;
  endfunction

  function automatic logic taken(input logic [2:0] br, input logic [XLEN-1:0] res);
    return is_branch(br) && (res == XLEN'(1));
  endfunction

  // Register 0 is never written and is masked on read as well.
  assign rs1_val = (rs1_reg == '0) ? '0 : rf[rs1_reg];
  assign rs2_val = (rs2_reg == '0) ? '0 : rf[rs2_reg];
  assign op2     = alu_src_reg ? imm_reg : rs2_val;

  mc_alu #(.XLEN(XLEN)) u_alu (
    .op (alu_ctl_reg),
    .a  (rs1_val),
    .b  (op2),
    .y  (alu_y)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_we
      assign we_vec[gi] = (gi != 0) && (state_reg == ST_WB) && reg_write_reg &&
                          (rd_reg == RA'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (we_vec[i]) rf[i] <= wb_data_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg         <= ST_IDLE;
      rs1_reg           <= '0;
      rs2_reg           <= '0;
      rd_reg            <= '0;
      alu_ctl_reg       <= '0;
      alu_src_reg       <= 1'b0;
      reg_write_reg     <= 1'b0;
      mem_read_reg      <= 1'b0;
      mem_write_reg     <= 1'b0;
      m2r_reg           <= 1'b0;
      lui_reg           <= 1'b0;
      br_reg            <= '0;
      imm_reg           <= '0;
      imm_lui_reg       <= '0;
      alu_res_reg       <= '0;
      store_data_reg    <= '0;
      load_data_reg     <= '0;
      wb_data_reg       <= '0;
      mem_req_valid_reg <= 1'b0;
      done_reg          <= 1'b0;
      branch_reg        <= 1'b0;
    end else begin
      done_reg   <= 1'b0;
      branch_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            rs1_reg       <= rs1;
            rs2_reg       <= rs2;
            rd_reg        <= rd;
            alu_ctl_reg   <= alu_control;
            alu_src_reg   <= alu_src;
            reg_write_reg <= reg_write;
            mem_read_reg  <= mem_read;
            mem_write_reg <= mem_write;
            m2r_reg       <= mem_to_reg;
            lui_reg       <= lui_control;
            br_reg        <= br_type;
            imm_reg       <= imm_val;
            imm_lui_reg   <= imm_val_lui;
            state_reg     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          alu_res_reg    <= alu_y;
          store_data_reg <= rs2_val;
          if (mem_read_reg || mem_write_reg) begin
            mem_req_valid_reg <= 1'b1;
            state_reg         <= ST_MEM_REQ;
          end else begin
            wb_data_reg <= select_wb(lui_reg, m2r_reg, imm_lui_reg, load_data_reg, alu_y);
            branch_reg  <= taken(br_reg, alu_y);
            done_reg    <= 1'b1;
            state_reg   <= ST_WB;
          end
        end
        ST_MEM_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid_reg <= 1'b0;
            // A command with both read and write set is handled as a store.
            if (mem_write_reg) begin
              wb_data_reg <= select_wb(lui_reg, m2r_reg, imm_lui_reg, load_data_reg, alu_res_reg);
              branch_reg  <= taken(br_reg, alu_res_reg);
              done_reg    <= 1'b1;
              state_reg   <= ST_WB;
            end else begin
              state_reg <= ST_MEM_WAIT;
            end
          end
        end
        ST_MEM_WAIT: begin
          if (mem_rsp_valid) begin
            load_data_reg <= mem_rsp_rdata;
            wb_data_reg   <= select_wb(lui_reg, m2r_reg, imm_lui_reg, mem_rsp_rdata, alu_res_reg);
            branch_reg    <= taken(br_reg, alu_res_reg);
            done_reg      <= 1'b1;
            state_reg     <= ST_WB;
          end
        end
        ST_WB:   state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready     = rst && (state_reg == ST_IDLE);
  assign mem_req_valid = mem_req_valid_reg;
  assign mem_req_we    = mem_write_reg;
  assign mem_req_addr  = alu_res_reg;
  assign mem_req_wdata = store_data_reg;
  assign done_valid    = done_reg;
  assign branch_taken  = branch_reg;
  assign wb_data       = wb_data_reg;

endmodule
